// File: rtl/sm_directory_multi.sv
// MSI directory for NUM_BLOCKS blocks shared by NUM_NODES caches.
// Requests are serialised one at a time; owners are fetched and sharers invalidated as needed.
module sm_directory_multi #(
    parameter int NUM_NODES  = 4,
    parameter int NODE_WIDTH = 2,
    parameter int NUM_BLOCKS = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_type,
    input  logic [NODE_WIDTH-1:0] req_node,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  fetch_valid,
    output logic [NODE_WIDTH-1:0] fetch_node,
    output logic                  fetch_inv,
    input  logic                  fetch_ack,
    output logic [NUM_NODES-1:0]  inv_vec,
    output logic                  reply_valid,
    output logic [NODE_WIDTH-1:0] reply_node,
    output logic [ADDR_WIDTH-1:0] reply_addr,
    output logic                  err,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [1:0]            dbg_state,
    output logic [NUM_NODES-1:0]  dbg_sharers
);

    localparam logic [1:0] BLK_UNC = 2'b00;
    localparam logic [1:0] BLK_SHR = 2'b01;
    localparam logic [1:0] BLK_MOD = 2'b10;
    localparam logic [1:0] REQ_RD  = 2'b00;
    localparam logic [1:0] REQ_WR  = 2'b01;
    localparam logic [1:0] REQ_WB  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_EXEC       = 2'b01,
        ST_WAIT_FETCH = 2'b10,
        ST_REPLY      = 2'b11
    } ctrl_t;

    function automatic logic [NODE_WIDTH-1:0] onehot_to_idx(input logic [NUM_NODES-1:0] v);
        logic [NODE_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            idx = idx | (v[i] ? NODE_WIDTH'(i) : '0);
        end
        return idx;
    endfunction

    function automatic logic [NUM_NODES-1:0] idx_to_onehot(input logic [NODE_WIDTH-1:0] idx);
        logic [NUM_NODES-1:0] v;
        for (int i = 0; i < NUM_NODES; i++) begin
            v[i] = (NODE_WIDTH'(i) == idx);
        end
        return v;
    endfunction

    ctrl_t                 state_r, state_s;
    logic [1:0]            blk_state_r   [NUM_BLOCKS];
    logic [NUM_NODES-1:0]  blk_sharers_r [NUM_BLOCKS];
    logic [1:0]            lat_type_r;
    logic [NODE_WIDTH-1:0] lat_node_r;
    logic [ADDR_WIDTH-1:0] lat_addr_r;

    logic                  fetch_valid_r, fetch_inv_r;
    logic [NODE_WIDTH-1:0] fetch_node_r;
    logic [NUM_NODES-1:0]  inv_vec_r;
    logic                  reply_valid_r, err_r;
    logic [NODE_WIDTH-1:0] reply_node_r;
    logic [ADDR_WIDTH-1:0] reply_addr_r;

    logic                  addr_ok_s;
    logic [1:0]            cur_state_s;
    logic [NUM_NODES-1:0]  cur_sharers_s, n_s;
    logic                  upd_s, fetch_start_s, fetch_inv_s, err_s;
    logic [1:0]            upd_state_s;
    logic [NUM_NODES-1:0]  upd_sharers_s, inv_s;

    assign addr_ok_s     = ({1'b0, lat_addr_r} < (ADDR_WIDTH + 1)'(NUM_BLOCKS));
    assign cur_state_s   = addr_ok_s ? blk_state_r[lat_addr_r] : BLK_UNC;
    assign cur_sharers_s = addr_ok_s ? blk_sharers_r[lat_addr_r] : '0;
    assign n_s           = idx_to_onehot(lat_node_r);

    // Next control state, entry update and pulse decisions
    always_comb begin
        state_s       = state_r;
        upd_s         = 1'b0;
        upd_state_s   = cur_state_s;
        upd_sharers_s = cur_sharers_s;
        fetch_start_s = 1'b0;
        fetch_inv_s   = 1'b0;
        inv_s         = '0;
        err_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_s = ST_IDLE;
                if (!addr_ok_s) begin
                    err_s = 1'b1;
                end else if (lat_type_r == REQ_RD || lat_type_r == REQ_WR) begin
                    state_s = ST_REPLY;
                    case (cur_state_s)
                        BLK_UNC: begin
                            upd_s         = 1'b1;
                            upd_state_s   = (lat_type_r == REQ_RD) ? BLK_SHR : BLK_MOD;
                            upd_sharers_s = n_s;
                        end
                        BLK_SHR: begin
                            upd_s = 1'b1;
                            if (lat_type_r == REQ_RD) begin
                                upd_sharers_s = cur_sharers_s | n_s;
                            end else begin
                                inv_s         = cur_sharers_s & ~n_s;
                                upd_state_s   = BLK_MOD;
                                upd_sharers_s = n_s;
                            end
                        end
                        BLK_MOD: begin
                            // Owner re-requesting its own block needs no coherence action
                            if (cur_sharers_s != n_s) begin
                                fetch_start_s = 1'b1;
                                fetch_inv_s   = (lat_type_r == REQ_WR);
                                state_s       = ST_WAIT_FETCH;
                            end else begin
                                state_s = ST_REPLY;
                            end
                        end
                        default: begin
                            err_s   = 1'b1;
                            state_s = ST_IDLE;
                        end
                    endcase
                end else if (lat_type_r == REQ_WB && cur_state_s == BLK_MOD && cur_sharers_s == n_s) begin
                    upd_s         = 1'b1;
                    upd_state_s   = BLK_UNC;
                    upd_sharers_s = '0;
                end else begin
                    err_s = 1'b1;
                end
            end
            ST_WAIT_FETCH: begin
                if (fetch_ack) begin
                    upd_s   = 1'b1;
                    state_s = ST_REPLY;
                    if (lat_type_r == REQ_WR) begin
                        upd_state_s   = BLK_MOD;
                        upd_sharers_s = n_s;
                    end else begin
                        upd_state_s   = BLK_SHR;
                        upd_sharers_s = idx_to_onehot(fetch_node_r) | n_s;
                    end
                end else begin
                    state_s = ST_WAIT_FETCH;
                end
            end
            ST_REPLY: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Control state and latched request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            lat_type_r <= 2'b00;
            lat_node_r <= '0;
            lat_addr_r <= '0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_IDLE && req_valid) begin
                lat_type_r <= req_type;
                lat_node_r <= req_node;
                lat_addr_r <= req_addr;
            end else begin
                lat_type_r <= lat_type_r;
            end
        end
    end

    // Directory entries
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                blk_state_r[i]   <= BLK_UNC;
                blk_sharers_r[i] <= '0;
            end
        end else if (upd_s) begin
            blk_state_r[lat_addr_r]   <= upd_state_s;
            blk_sharers_r[lat_addr_r] <= upd_sharers_s;
        end else begin
            blk_state_r[0] <= blk_state_r[0];
        end
    end

    // Registered message outputs; fetch is held until the owner acknowledges
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_valid_r <= 1'b0;
            fetch_node_r  <= '0;
            fetch_inv_r   <= 1'b0;
            inv_vec_r     <= '0;
            err_r         <= 1'b0;
            reply_valid_r <= 1'b0;
            reply_node_r  <= '0;
            reply_addr_r  <= '0;
        end else begin
            inv_vec_r     <= inv_s;
            err_r         <= err_s;
            reply_valid_r <= (state_s == ST_REPLY);
            if (fetch_start_s) begin
                fetch_valid_r <= 1'b1;
                fetch_node_r  <= onehot_to_idx(cur_sharers_s);
                fetch_inv_r   <= fetch_inv_s;
            end else if (state_r == ST_WAIT_FETCH && fetch_ack) begin
                fetch_valid_r <= 1'b0;
            end else begin
                fetch_valid_r <= fetch_valid_r;
            end
            if (state_s == ST_REPLY) begin
                reply_node_r <= lat_node_r;
                reply_addr_r <= lat_addr_r;
            end else begin
                reply_node_r <= reply_node_r;
            end
        end
    end

    // Debug view of one entry
    always_comb begin
        dbg_state   = BLK_UNC;
        dbg_sharers = '0;
        if ({1'b0, dbg_addr} < (ADDR_WIDTH + 1)'(NUM_BLOCKS)) begin
            dbg_state   = blk_state_r[dbg_addr];
            dbg_sharers = blk_sharers_r[dbg_addr];
        end else begin
            dbg_state = BLK_UNC;
        end
    end

    assign req_ready   = (state_r == ST_IDLE);
    assign fetch_valid = fetch_valid_r;
    assign fetch_node  = fetch_node_r;
    assign fetch_inv   = fetch_inv_r;
    assign inv_vec     = inv_vec_r;
    assign err         = err_r;
    assign reply_valid = reply_valid_r;
    assign reply_node  = reply_node_r;
    assign reply_addr  = reply_addr_r;

endmodule

// File: tb/tb_sm_directory_multi.sv
// Directed bench for sm_directory_multi: a transaction-level MSI model sets the expected
// outputs each cycle and a negedge process compares them with the DUT.
module tb_sm_directory_multi;

    localparam int NN = 4;
    localparam int NW = 2;
    localparam int NB = 8;
    localparam int AW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready;
    logic [1:0]    req_type;
    logic [NW-1:0] req_node;
    logic [AW-1:0] req_addr;
    logic          fetch_valid, fetch_inv, fetch_ack;
    logic [NW-1:0] fetch_node;
    logic [NN-1:0] inv_vec;
    logic          reply_valid, err;
    logic [NW-1:0] reply_node;
    logic [AW-1:0] reply_addr;
    logic [AW-1:0] dbg_addr;
    logic [1:0]    dbg_state;
    logic [NN-1:0] dbg_sharers;

    sm_directory_multi #(.NUM_NODES(NN), .NODE_WIDTH(NW), .NUM_BLOCKS(NB), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_node(req_node), .req_addr(req_addr),
        .fetch_valid(fetch_valid), .fetch_node(fetch_node), .fetch_inv(fetch_inv),
        .fetch_ack(fetch_ack), .inv_vec(inv_vec),
        .reply_valid(reply_valid), .reply_node(reply_node), .reply_addr(reply_addr),
        .err(err), .dbg_addr(dbg_addr), .dbg_state(dbg_state), .dbg_sharers(dbg_sharers)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: block state as 0=U,1=S,2=M and sharers as a plain integer bitmask
    int m_state [NB];
    int m_sh    [NB];

    logic          e_ready, e_reply, e_err, e_fv, e_finv;
    logic [NW-1:0] e_rnode, e_fnode;
    logic [AW-1:0] e_raddr;
    logic [NN-1:0] e_inv;
    bit            chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_exp();
        e_ready = 1'b1; e_reply = 1'b0; e_err = 1'b0; e_fv = 1'b0; e_finv = 1'b0;
        e_rnode = '0; e_fnode = '0; e_raddr = '0; e_inv = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_state[i] = 0;
            m_sh[i]    = 0;
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("reply_valid", 32'(reply_valid), 32'(e_reply));
            if (e_reply) begin
                chk("reply_node", 32'(reply_node), 32'(e_rnode));
                chk("reply_addr", 32'(reply_addr), 32'(e_raddr));
            end
            chk("err", 32'(err), 32'(e_err));
            chk("inv_vec", 32'(inv_vec), 32'(e_inv));
            chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
            if (e_fv) begin
                chk("fetch_node", 32'(fetch_node), 32'(e_fnode));
                chk("fetch_inv", 32'(fetch_inv), 32'(e_finv));
            end
            chk("dbg_state", 32'(dbg_state), 32'(m_state[dbg_addr]));
            chk("dbg_sharers", 32'(dbg_sharers), 32'(m_sh[dbg_addr]));
        end
    end

    // One full request; called #1 after a rising edge while the DUT is idle
    task automatic txn(input int typ, input int node, input int addr, input int waits);
        int st, sh, n, kind, owner, inv, nst, nsh;
        n = 1 << node; st = m_state[addr]; sh = m_sh[addr];
        inv = 0; nst = st; nsh = sh; owner = 0;
        if (typ == 3) kind = 1;
        else if (typ == 2) begin
            if (st == 2 && sh == n) begin kind = 2; nst = 0; nsh = 0; end
            else kind = 1;
        end
        else if (st == 0) begin kind = 0; nst = (typ == 0) ? 1 : 2; nsh = n; end
        else if (st == 1) begin
            kind = 0;
            if (typ == 0) nsh = sh | n;
            else begin inv = sh & ~n; nst = 2; nsh = n; end
        end
        else if (sh == n) kind = 0;
        else begin kind = 3; owner = $clog2(sh); end

        dbg_addr = AW'(addr);
        req_valid = 1'b1; req_type = 2'(typ); req_node = NW'(node); req_addr = AW'(addr);
        @(posedge clock); #1;
        req_valid = 1'b0; e_ready = 1'b0;
        @(posedge clock); #1;
        case (kind)
            0: begin
                e_reply = 1'b1; e_rnode = NW'(node); e_raddr = AW'(addr); e_inv = NN'(inv);
                m_state[addr] = nst; m_sh[addr] = nsh;
                @(posedge clock); #1;
                idle_exp();
            end
            1: begin
                e_err = 1'b1; e_ready = 1'b1;
                @(posedge clock); #1;
                idle_exp();
            end
            2: begin
                m_state[addr] = nst; m_sh[addr] = nsh;
                idle_exp();
                @(posedge clock); #1;
            end
            default: begin
                e_fv = 1'b1; e_fnode = NW'(owner); e_finv = (typ == 1);
                repeat (waits) begin @(posedge clock); #1; end
                fetch_ack = 1'b1;
                @(posedge clock); #1;
                fetch_ack = 1'b0; e_fv = 1'b0;
                e_reply = 1'b1; e_rnode = NW'(node); e_raddr = AW'(addr);
                if (typ == 0) begin m_state[addr] = 1; m_sh[addr] = (1 << owner) | n; end
                else begin m_state[addr] = 2; m_sh[addr] = n; end
                @(posedge clock); #1;
                idle_exp();
            end
        endcase
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_type = 2'b00; req_node = '0; req_addr = '0;
        fetch_ack = 1'b0; dbg_addr = '0;
        model_reset(); idle_exp();
        repeat (2) @(posedge clock); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_reply_valid", 32'(reply_valid), 32'd0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_dbg_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Read miss on an uncached block
        txn(0, 1, 2, 0);
        chk("t1_state", 32'(dbg_state), 32'h1);
        chk("t1_sharers", 32'(dbg_sharers), 32'b0010);

        // Sharers grow, then a write miss invalidates the others
        txn(0, 0, 2, 0);
        txn(0, 3, 2, 0);
        chk("t2_sharers_pre", 32'(dbg_sharers), 32'b1011);
        txn(1, 3, 2, 0);
        chk("t2_state", 32'(dbg_state), 32'h2);
        chk("t2_sharers", 32'(dbg_sharers), 32'b1000);

        // Owner 3 fetched for a read miss from node 0
        txn(0, 0, 2, 5);
        chk("t3_state", 32'(dbg_state), 32'h1);
        chk("t3_sharers", 32'(dbg_sharers), 32'b1001);

        // Back to Modified owner 3, then fetch/invalidate for node 2
        txn(1, 3, 2, 0);
        txn(1, 2, 2, 3);
        chk("t4_state", 32'(dbg_state), 32'h2);
        chk("t4_sharers", 32'(dbg_sharers), 32'b0100);

        // Write backs: non-owner rejected, owner accepted
        txn(2, 1, 2, 0);
        chk("t5_err_state", 32'(dbg_state), 32'h2);
        chk("t5_err_sharers", 32'(dbg_sharers), 32'b0100);
        txn(2, 2, 2, 0);
        chk("t5_wb_state", 32'(dbg_state), 32'h0);
        chk("t5_wb_sharers", 32'(dbg_sharers), 32'b0000);

        // Illegal type, stray ack, owner re-request, other blocks
        txn(3, 0, 5, 0);
        fetch_ack = 1'b1;
        @(posedge clock); #1;
        fetch_ack = 1'b0;
        txn(1, 0, 7, 0);
        txn(0, 0, 7, 0);
        chk("t6_state", 32'(dbg_state), 32'h2);
        chk("t6_sharers", 32'(dbg_sharers), 32'b0001);
        txn(2, 1, 6, 0);

        // Reset while waiting for a fetch acknowledge
        txn(1, 1, 4, 0);
        dbg_addr = 3'd4;
        req_valid = 1'b1; req_type = 2'b00; req_node = 2'd0; req_addr = 3'd4;
        @(posedge clock); #1;
        req_valid = 1'b0; e_ready = 1'b0;
        @(posedge clock); #1;
        e_fv = 1'b1; e_fnode = 2'd1; e_finv = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        chk_en = 1'b0;
        chk("t7_fetch_before", 32'(fetch_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t7_fetch_async", 32'(fetch_valid), 32'd0);
        chk("t7_ready_async", 32'(req_ready), 32'd1);
        for (int i = 0; i < NB; i++) begin
            dbg_addr = AW'(i);
            #1;
            chk("t7_entry_state", 32'(dbg_state), 32'd0);
            chk("t7_entry_sharers", 32'(dbg_sharers), 32'd0);
        end
        model_reset(); idle_exp();
        @(posedge clock); #1;
        reset = 1'b0;
        chk_en = 1'b1;
        txn(0, 2, 4, 0);
        chk("t8_state", 32'(dbg_state), 32'h1);
        chk("t8_sharers", 32'(dbg_sharers), 32'b0100);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm_directory_multi.md
Name: sm_directory_multi

Overview:
Parametrised successor to the single-block MSI directory state machine. Tracks coherence state and a sharers bit-vector for NUM_BLOCKS memory blocks across NUM_NODES caches. Serialises requests through a valid/ready handshake. Issues invalidate and fetch messages, waits for owner acknowledgement, then returns a data-value reply. Sits between the cache-block controllers (sm_cblock instances) and memory. Debug ports drive board LEDs and seven-segment displays.

Parameters:
NUM_NODES, 4, number of caches; width of the sharers vector.
NODE_WIDTH, 2, bits of node ID; 2**NODE_WIDTH >= NUM_NODES.
NUM_BLOCKS, 8, number of tracked memory blocks.
ADDR_WIDTH, 3, block index width; 2**ADDR_WIDTH >= NUM_BLOCKS.

Ports:
clock  in  1  sole clock, rising edge.
reset  in  1  asynchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  directory can accept a request.
req_type  in  2  00 read miss, 01 write miss, 10 write back, 11 illegal.
req_node  in  NODE_WIDTH  requesting node.
req_addr  in  ADDR_WIDTH  block index.
fetch_valid  out  1  fetch message to the owner, held until ack.
fetch_node  out  NODE_WIDTH  owner being fetched.
fetch_inv  out  1  1 = fetch/invalidate, 0 = fetch only.
fetch_ack  in  1  owner has written back data.
inv_vec  out  NUM_NODES  one-cycle invalidate pulse, one bit per node.
reply_valid  out  1  one-cycle data-value-reply pulse.
reply_node  out  NODE_WIDTH  reply destination.
reply_addr  out  ADDR_WIDTH  reply block.
err  out  1  one-cycle pulse on illegal request.
dbg_addr  in  ADDR_WIDTH  block selected for debug view.
dbg_state  out  2  state of block dbg_addr (combinational).
dbg_sharers  out  NUM_NODES  sharers of block dbg_addr (combinational).

Behaviour:
- Block state encoding: 00 Uncached, 01 Shared, 10 Modified. Code 11 is never stored.
- In Modified, the sharers vector is one-hot and its set bit is the owner.
- Reset (asynchronous, including mid-transaction):
  - All entries go to Uncached with sharers 0.
  - Control FSM goes to IDLE.
  - All outputs go to 0, except req_ready, which goes to 1.
- Control FSM states: IDLE, EXEC, WAIT_FETCH, REPLY.
- IDLE:
  - req_ready = 1.
  - A handshake (req_valid & req_ready) latches type, node and addr, then moves to EXEC.
  - req_ready = 0 in every other state.
- EXEC (one cycle) acts on the latched request and the entry state; "n" is the one-hot vector of req_node:
  - Uncached + read miss: state Shared, sharers = n, go to REPLY.
  - Uncached + write miss: state Modified, sharers = n, go to REPLY.
  - Shared + read miss: sharers |= n, go to REPLY.
  - Shared + write miss: inv_vec = sharers & ~n for this cycle only; state Modified; sharers = n; go to REPLY. inv_vec = 0 produces no pulse.
  - Modified + read/write miss with owner == requester: no change, go to REPLY.
  - Modified + read miss from another node: fetch_valid = 1, fetch_node = owner, fetch_inv = 0, go to WAIT_FETCH.
  - Modified + write miss from another node: same as the read-miss case, but fetch_inv = 1.
  - Write back when state is Modified and owner == req_node: state Uncached, sharers = 0, return to IDLE with no reply.
  - Write back in any other case, or type 11: err pulses, no state change, return to IDLE.
- WAIT_FETCH:
  - fetch_valid, fetch_node and fetch_inv are held stable until fetch_ack is sampled high.
  - On that edge, fetch_valid drops.
  - Read miss: state Shared, sharers = owner | n.
  - Write miss: state Modified, sharers = n.
  - Then go to REPLY.
  - fetch_ack outside WAIT_FETCH is ignored.
- REPLY: reply_valid = 1 for one cycle, with reply_node/reply_addr taken from the latched request, then IDLE.
- Latency:
  - No fetch: handshake edge at cycle 0, EXEC at cycle 1, reply_valid at cycle 2, req_ready back at cycle 3.
  - With fetch: reply comes one cycle after the ack edge.
- Throughput: at most one request in flight. Requests to different blocks are also serialised.
- Entry updates take effect on the clock edge leaving EXEC or WAIT_FETCH. dbg_* reflect the updated value from the next cycle.
- Out-of-range req_addr >= NUM_BLOCKS (when not a power of two): err pulse, no update.

Test Plan:
- Reset, then read miss from node 1 to addr 2:
  - reply_valid pulses at cycle 2 with reply_node = 1.
  - dbg_state = 01 and dbg_sharers = 0010.
- Read misses from nodes 0 and 3 to addr 2, then write miss from node 3:
  - inv_vec = 0011 for exactly one cycle.
  - Final state 10 with sharers 1000.
- Modified (owner 3) + read miss from node 0:
  - fetch_valid is held with fetch_node = 3 and fetch_inv = 0 through 5 wait cycles.
  - After ack, state 01 with sharers 1001, and reply one cycle later.
- Modified (owner 3) + write miss from node 2: fetch_inv = 1; after ack, state 10 with sharers 0100.
- Write back from non-owner node 1: err pulses and the entry is unchanged. Write back from owner node 2: state 00 with sharers 0000, and no reply.
- Assert reset while in WAIT_FETCH:
  - fetch_valid drops immediately, with no clock edge.
  - All entries read 00/0000 and req_ready = 1.
